// File: rtl/if_stage_pkg.sv
// Shared fetch definitions: NOP fill word, fetch FSM encodings, and the RV32I
// base opcodes that the fetch stage and the control decoder both use.
package if_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats stall beats load; any cycle without a
// delivered instruction becomes a NOP bubble so decode never sees stale words.
module ifid_reg #(
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= 32'd0;
      pc4   <= 32'd4;
    end else if (flush) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (!stall) begin
      if (load) begin
        valid <= 1'b1;
        inst  <= load_inst;
        pc    <= load_pc;
        pc4   <= load_pc + 32'd4;
      end else begin
        valid <= 1'b0;
        inst  <= NOP_INST;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, skid slot and
// IF/ID register. Defining IF_PERF_CNT_EN adds perf_fetched/perf_killed counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);

  import if_stage_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         kill;
  logic [31:0]  skid_inst;
  logic [31:0]  skid_pc;

  logic         deliver;
  logic         drop;
  logic [31:0]  deliver_inst;
  logic [31:0]  deliver_pc;

  assign imem_req  = rst_n && (state == IDLE) && !redirect;
  assign imem_addr = pc;

  // A response is either handed to IF/ID, parked in the skid, or dropped.
  always_comb begin
    deliver      = 1'b0;
    drop         = 1'b0;
    deliver_inst = skid_inst;
    deliver_pc   = skid_pc;
    case (state)
      WAIT: begin
        if (imem_rvalid) begin
          if (kill || redirect) begin
            drop = 1'b1;
          end else if (!stall) begin
            deliver      = 1'b1;
            deliver_inst = imem_rdata;
            deliver_pc   = req_pc;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          drop = 1'b1;
        end else if (!stall) begin
          deliver = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      kill      <= 1'b0;
      skid_inst <= NOP_INST;
      skid_pc   <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (imem_req && imem_gnt) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
            if (kill || redirect || !stall) begin
              state <= IDLE;
            end else begin
              skid_inst <= imem_rdata;
              skid_pc   <= req_pc;
              state     <= HOLD;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || !stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Redirect always wins the PC, even over a same-cycle grant or stall.
      if (redirect) begin
        pc <= word_align(redirect_pc);
      end
    end
  end

  ifid_reg #(
    .NOP_INST(NOP_INST)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .stall    (stall),
    .load     (deliver),
    .load_inst(deliver_inst),
    .load_pc  (deliver_pc),
    .valid    (ifid_valid),
    .inst     (ifid_inst),
    .pc       (ifid_pc),
    .pc4      (ifid_pc4)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_killed  <= 32'd0;
    end else begin
      if (deliver) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (drop) begin
        perf_killed <= perf_killed + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage with an integrated IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Presents fetched words (inst, pc) to the decode/control stage.
- Accepts stall from the hazard logic and redirect (taken branch, JAL, JALR) from execute; discards stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, word driven on ifid_inst when the slot is invalid (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold IF/ID contents and PC; no new instruction enters decode
- redirect  input  1  control-flow change this cycle
- redirect_pc  input  32  target; bits [1:0] ignored (forced 0)
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address (word aligned)
- imem_gnt  input  1  request accepted when imem_req && imem_gnt
- imem_rvalid  input  1  response valid, earliest 1 cycle after grant, in order
- imem_rdata  input  32  instruction word
- ifid_valid  output  1  IF/ID slot holds a live instruction
- ifid_inst  output  32  instruction to control/decoder
- ifid_pc  output  32  PC of ifid_inst
- ifid_pc4  output  32  ifid_pc + 4 (JAL/JALR link value)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, kill=0, skid empty
  - ifid_valid=0, ifid_inst=NOP_INST, ifid_pc=0, ifid_pc4=4
  - imem_req=0 while in reset
- States IDLE, WAIT, HOLD; at most one outstanding request.
- IDLE:
  - imem_req = !redirect; imem_addr=pc.
  - On grant: req_pc<=pc, pc<=pc+4, go WAIT.
- WAIT: wait for imem_rvalid.
  - rvalid with kill=1 or redirect=1: drop response, clear kill, go IDLE.
  - rvalid with !stall: load IF/ID {valid=1, inst=rdata, pc=req_pc, pc4=req_pc+4}, go IDLE.
  - rvalid with stall: capture {rdata, req_pc} in skid, go HOLD.
  - redirect without rvalid: kill<=1, stay WAIT.
- HOLD:
  - !stall: move skid into IF/ID, go IDLE.
  - redirect: drop skid, go IDLE.
- Redirect, any state: pc<={redirect_pc[31:2],2'b00} at the edge; overrides stall.
- IF/ID register:
  - redirect=1: valid<=0, inst<=NOP_INST; highest priority.
  - else stall=1: hold all fields.
  - else if no instruction delivered this cycle: valid<=0, inst<=NOP_INST (bubble).
- ifid_inst=NOP_INST whenever ifid_valid=0; the decoder never sees stale words.
- pc arithmetic mod 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Throughput: one instruction per 2 cycles with zero-wait memory (grant same cycle, rvalid next).
- Reset mid-WAIT: outstanding response ignored; memory must not deliver a response across reset.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - adds outputs perf_fetched[31:0] and perf_killed[31:0], reset 0, wrap at 2^32.
  - perf_fetched increments on each instruction loaded into IF/ID with valid=1.
  - perf_killed increments on each dropped response or dropped skid entry.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package/header:
  - NOP_INST constant
  - fetch state encodings (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2)
  - RISC-V opcode constants shared with the control decoder
- Sub-module ifid_reg: IF/ID pipeline register with flush/stall priority and NOP fill. The fetch FSM, PC and skid stay in if_stage.

Test Plan:
- Reset release, memory gnt=1, rvalid next cycle with words at 0x0,0x4,0x8 -> ifid_pc sequence 0x0,0x4,0x8 with valid pulses every 2nd cycle; ifid_pc4 = pc+4.
- stall=1 asserted the cycle rvalid returns inst 0x00500093 at pc 0x8 -> state HOLD, IF/ID unchanged; stall drop -> ifid_inst=0x00500093, ifid_pc=0x8 next cycle.
- redirect=1, redirect_pc=0x103 while WAIT at pc 0x10 -> response for 0x10 dropped, next imem_addr=0x100, ifid_valid=0 meanwhile.
- redirect and stall together while ifid_valid=1 -> ifid_valid=0, ifid_inst=0x00000013 next cycle.
- rst_n pulled low for 1 cycle in WAIT -> all outputs at reset values immediately; first request after release at RESET_PC.
- pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000; with IF_PERF_CNT_EN, perf_fetched and perf_killed match the counts of delivered and dropped responses.
